// File: rtl/seq_divider_if.sv
// Start/operand/result bundle between the ALU controller and the sequential divider.
interface seq_divider_if #(
  parameter int unsigned width = 8
);
  logic             start;
  logic [width-1:0] dividend;
  logic [width-1:0] divisor;
  logic [width-1:0] quotient;
  logic [width-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider: one quotient bit per clock, with divide-by-zero bypass.
module seq_divider #(
  parameter int unsigned width = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  bus
);

  localparam int unsigned cnt_w = $clog2(width);
  localparam int unsigned rw    = width + 1;
  localparam int unsigned sw    = 2 * width + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [width:0]   r_q;
  logic [width-1:0] q_q;
  logic [width-1:0] d_q;
  logic [cnt_w-1:0] cnt_q;

  logic             load_c;
  logic             zero_c;
  logic             step_c;
  logic             cnt_last_c;
  logic             div_zero_c;

  logic [2*width:0] rq_shift_c;
  logic [width:0]   r_shift_c;
  logic [width:0]   trial_c;
  logic [width:0]   r_next_c;
  logic [width-1:0] q_next_c;

  assign cnt_last_c = (cnt_q == cnt_w'(width - 1));
  assign div_zero_c = (bus.divisor == '0);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE: begin
        if (bus.start) state_next = div_zero_c ? DONE : RUN;
        else           state_next = IDLE;
      end
      RUN:     state_next = cnt_last_c ? DONE : RUN;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath control decode
  always_comb begin
    load_c = 1'b0;
    zero_c = 1'b0;
    step_c = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          zero_c = div_zero_c;
          load_c = !div_zero_c;
        end
      end
      RUN:     step_c = 1'b1;
      default: ;
    endcase
  end

  // Trial subtraction on the shifted {R,Q}; R keeps a guard bit so the sign of T is exact
  always_comb begin
    rq_shift_c = {r_q, q_q} << 1;
    r_shift_c  = rq_shift_c[2*width:width];
    trial_c    = rw'(r_shift_c + ~{1'b0, d_q} + rw'(1));
    r_next_c   = trial_c[width] ? r_shift_c : trial_c;
    q_next_c   = rq_shift_c[width-1:0] | {{(width-1){1'b0}}, ~trial_c[width]};
  end

  // Working registers and registered results
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q             <= '0;
      q_q             <= '0;
      d_q             <= '0;
      cnt_q           <= '0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
    end else begin
      if (load_c) begin
        r_q   <= '0;
        q_q   <= bus.dividend;
        d_q   <= bus.divisor;
        cnt_q <= '0;
      end else if (step_c) begin
        r_q   <= r_next_c;
        q_q   <= q_next_c;
        cnt_q <= cnt_q + cnt_w'(1);
      end

      if (zero_c) begin
        bus.quotient    <= '1;
        bus.remainder   <= bus.dividend;
        bus.div_by_zero <= 1'b1;
      end else if (step_c && cnt_last_c) begin
        bus.quotient    <= q_next_c;
        bus.remainder   <= r_next_c[width-1:0];
        bus.div_by_zero <= 1'b0;
      end

      bus.busy <= (state_next == RUN);
      bus.done <= (state_next == DONE);
    end
  end

endmodule
